// File: rtl/proc_control_if.sv
// Control-to-datapath signal bundle for the 9-bit processor: fetch inputs
// plus every bus, register-file and ALU strobe driven by the control unit.
interface proc_control_if #(
  parameter int DATA_W = 9,
  parameter int NREG   = 8
);
  logic              run;
  logic [DATA_W-1:0] din;
  logic              ir_load;
  logic [NREG-1:0]   rout;
  logic [NREG-1:0]   rin;
  logic              din_out;
  logic              gout;
  logic              gin;
  logic              ain;
  logic [1:0]        alu_en;
  logic              busy;
  logic              done;

  // The control unit is the initiator of every strobe.
  modport master (
    input  run, din,
    output ir_load, rout, rin, din_out, gout, gin, ain, alu_en, busy, done
  );

  // The datapath (or a bench standing in for it) supplies run/din.
  modport slave (
    output run, din,
    input  ir_load, rout, rin, din_out, gout, gin, ain, alu_en, busy, done
  );
endinterface

// File: rtl/proc_control.sv
// Multi-cycle control unit: fetches a 9-bit instruction and sequences the
// register-file, A, ALU and G strobes over T0..T3 (2 or 4 cycles per op).
module proc_control #(
  parameter int DATA_W = 9,
  parameter int NREG   = 8
) (
  input  logic           clk,
  input  logic           reset,
  proc_control_if.master ctl
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  typedef enum logic [1:0] {
    ALU_ZERO = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_POP  = 2'b11
  } alu_op_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_POP = 3'b100;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] ir;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       alu_op;

  assign op = ir[8:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];
  assign alu_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_POP);

  function automatic logic [NREG-1:0] one_hot(input logic [2:0] idx);
    one_hot = {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  // State and instruction register. IR only captures in T0 so run is
  // effectively ignored for the rest of the instruction.
  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // blocking here would let later statements see already-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && ctl.run)
        ir <= ctl.din;
    end
  end

  // NOTE: assigning a default before the case keeps this purely combinational;
  // a path that leaves state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      T0:      state_nxt = ctl.run ? T1 : T0;
      T1:      state_nxt = alu_op ? T2 : T0;
      T2:      state_nxt = T3;
      T3:      state_nxt = T0;
      default: state_nxt = T0;
    endcase
  end

  // Moore strobes decoded from state and IR; ir_load alone also looks at run.
  always_comb begin
    ctl.ir_load = 1'b0;
    ctl.rout    = '0;
    ctl.rin     = '0;
    ctl.din_out = 1'b0;
    ctl.gout    = 1'b0;
    ctl.gin     = 1'b0;
    ctl.ain     = 1'b0;
    ctl.alu_en  = ALU_ZERO;
    ctl.done    = 1'b0;
    ctl.busy    = (state != T0);

    unique case (state)
      T0: ctl.ir_load = ctl.run;

      T1: begin
        unique case (op)
          OP_MV: begin
            ctl.rout = one_hot(ry);
            ctl.rin  = one_hot(rx);
            ctl.done = 1'b1;
          end
          OP_MVI: begin
            ctl.din_out = 1'b1;
            ctl.rin     = one_hot(rx);
            ctl.done    = 1'b1;
          end
          OP_ADD: begin
            ctl.rout   = one_hot(rx);
            ctl.ain    = 1'b1;
            ctl.alu_en = ALU_ADD;
          end
          OP_SUB: begin
            ctl.rout   = one_hot(rx);
            ctl.ain    = 1'b1;
            ctl.alu_en = ALU_SUB;
          end
          OP_POP: begin
            ctl.rout   = one_hot(ry);
            ctl.ain    = 1'b1;
            ctl.alu_en = ALU_POP;
          end
          default: ctl.done = 1'b1;
        endcase
      end

      // alu_en repeats the T1 value so it never changes around the A load.
      T2: begin
        if (alu_op) begin
          ctl.rout = one_hot(ry);
          ctl.gin  = 1'b1;
          unique case (op)
            OP_ADD:  ctl.alu_en = ALU_ADD;
            OP_SUB:  ctl.alu_en = ALU_SUB;
            default: ctl.alu_en = ALU_POP;
          endcase
        end
      end

      T3: begin
        ctl.gout = 1'b1;
        ctl.rin  = one_hot(rx);
        ctl.done = 1'b1;
      end

      default: ;
    endcase
  end

endmodule
